// File: rtl/game_pkg.sv
// Shared status codes and widths for the game state controller.
// Status codes are shared with the LCD and link logic on the peer board.
package game_pkg;

  localparam int unsigned SEC_W = 8;

  localparam logic [2:0] STAT_NORMAL        = 3'd0;
  localparam logic [2:0] STAT_MATCH_ING     = 3'd1;
  localparam logic [2:0] STAT_MATCH_CANCEL  = 3'd2;
  localparam logic [2:0] STAT_MATCH_SUCCESS = 3'd3;
  localparam logic [2:0] STAT_GAME_INITIAL  = 3'd4;
  localparam logic [2:0] STAT_GAME_CNTDOWN  = 3'd5;
  localparam logic [2:0] STAT_GAME_ING      = 3'd6;
  localparam logic [2:0] STAT_GAME_OVER     = 3'd7;

  typedef enum logic [2:0] {
    S_NORMAL        = STAT_NORMAL,
    S_MATCH_ING     = STAT_MATCH_ING,
    S_MATCH_CANCEL  = STAT_MATCH_CANCEL,
    S_MATCH_SUCCESS = STAT_MATCH_SUCCESS,
    S_GAME_INITIAL  = STAT_GAME_INITIAL,
    S_GAME_CNTDOWN  = STAT_GAME_CNTDOWN,
    S_GAME_ING      = STAT_GAME_ING,
    S_GAME_OVER     = STAT_GAME_OVER
  } stat_t;

  // States whose seconds counter runs and whose entry restarts the divider.
  function automatic logic is_timed(input stat_t s);
    return (s == S_MATCH_ING) || (s == S_GAME_CNTDOWN) || (s == S_GAME_ING);
  endfunction

endpackage

// File: rtl/game_state_ctrl_tick_div.sv
// Second-tick divider: counts 0..TICK_DIV-1, tick high while the count is TICK_DIV-1.
module tick_div #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is registered from the next count so it coincides with count == LAST
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_state_ctrl.sv
// System-state controller: match handshake, countdown, timed game and game-over hold,
// with a seconds counter, LED time bar and win flag.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV           = 100,
  parameter int unsigned GAME_SECS          = 80,
  parameter int unsigned CNTDOWN_SECS       = 3,
  parameter int unsigned MATCH_TIMEOUT_SECS = 30,
  parameter int unsigned LED_W              = 16,
  parameter int unsigned LED_STEP_SECS      = 5
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic             pb_ctl,
  input  logic [2:0]       peer_stat,
  input  logic             game_lost,
  output logic [2:0]       stat_out,
  output logic [SEC_W-1:0] sec_left,
  output logic             tick,
  output logic [LED_W-1:0] led,
  output logic             win
);

  stat_t            state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             win_q, win_d;
  logic             clr;
  logic             peer_match, sec_last, led_step;
  logic [SEC_W-1:0] elapsed;

  tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (clr),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    led_d      = led_q;
    win_d      = win_q;
    peer_match = (peer_stat == STAT_MATCH_ING) || (peer_stat == STAT_MATCH_SUCCESS);
    sec_last   = tick && (sec_q == SEC_W'(1));
    // elapsed seconds after this tick's decrement
    elapsed    = SEC_W'(GAME_SECS) - (sec_q - SEC_W'(1));
    led_step   = (elapsed != '0) && ((elapsed % SEC_W'(LED_STEP_SECS)) == '0);

    case (state_q)
      S_NORMAL: begin
        if (pb_ctl) begin
          state_d = S_MATCH_ING;
          sec_d   = SEC_W'(MATCH_TIMEOUT_SECS);
          win_d   = 1'b0;
        end
      end
      S_MATCH_ING: begin
        if (peer_match)              state_d = S_MATCH_SUCCESS;
        else if (pb_ctl || sec_last) state_d = S_MATCH_CANCEL;
        else if (tick)               sec_d   = sec_q - SEC_W'(1);
      end
      S_MATCH_CANCEL:  state_d = S_NORMAL;
      S_MATCH_SUCCESS: state_d = S_GAME_INITIAL;
      S_GAME_INITIAL: begin
        state_d = S_GAME_CNTDOWN;
        sec_d   = SEC_W'(CNTDOWN_SECS);
      end
      S_GAME_CNTDOWN: begin
        if (sec_last) begin
          state_d = S_GAME_ING;
          sec_d   = SEC_W'(GAME_SECS);
        end else if (tick) begin
          sec_d = sec_q - SEC_W'(1);
        end
      end
      S_GAME_ING: begin
        if (tick && led_step) led_d = led_q << 1;
        if (game_lost) begin
          state_d = S_GAME_OVER;
          win_d   = 1'b0;
        end else if (peer_stat == STAT_GAME_OVER) begin
          state_d = S_GAME_OVER;
          win_d   = 1'b1;
        end else if (sec_last) begin
          state_d = S_GAME_OVER;
          win_d   = 1'b0;
        end else if (tick) begin
          sec_d = sec_q - SEC_W'(1);
        end
      end
      S_GAME_OVER: begin
        if (pb_ctl) state_d = S_NORMAL;
      end
      default: state_d = S_NORMAL;
    endcase

    if (!is_timed(state_d)) sec_d = '0;
    if ((state_d == S_NORMAL) || (state_d == S_MATCH_ING) || (state_d == S_GAME_INITIAL))
      led_d = '1;
    clr = is_timed(state_d) && (state_d != state_q);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NORMAL;
      sec_q   <= '0;
      led_q   <= '1;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      led_q   <= led_d;
      win_q   <= win_d;
    end
  end

  assign stat_out = state_q;
  assign sec_left = sec_q;
  assign led      = led_q;
  assign win      = win_q;

endmodule
